rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width (2^ADDR_WIDTH registers, register 0 hardwired zero).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wb_en  input  1  grant enable; 0 blocks new grants.
REQ-006 SHALL have port req0_valid  input  1  requester 0 has a write-back pending.
REQ-007 SHALL have port req0_waddr  input  ADDR_WIDTH  requester 0 destination register.
REQ-008 SHALL have port req0_wdata  input  DATA_WIDTH  requester 0 write data.
REQ-009 SHALL have port req0_ready  output  1  requester 0 accepted this cycle.
REQ-010 SHALL have ports req1_valid, req1_waddr, req1_wdata, req1_ready, identical to REQ-006..009, for requester 1.
REQ-011 SHALL have port rf_wen  output  1  register-file write enable.
REQ-012 SHALL have port rf_waddr  output  ADDR_WIDTH  register-file write address.
REQ-013 SHALL have port rf_wdata  output  DATA_WIDTH  register-file write data.
REQ-014 SHALL have ports qaddr1, qaddr2  input  ADDR_WIDTH  read addresses being issued to the register file.
REQ-015 SHALL have ports fwd_hit1, fwd_hit2  output  1  and fwd_data1, fwd_data2  output  DATA_WIDTH  bypass results for qaddr1/qaddr2.

Function
REQ-016 SHALL grant at most one requester per cycle; a grant occurs only when wb_en=1 and the granted req*_valid=1.
REQ-017 SHALL drive reqN_ready=1 combinationally, in the same cycle, exactly when requester N is granted; a transfer occurs on a posedge with reqN_valid=1 and reqN_ready=1.
REQ-018 SHALL, with one requester valid, grant it regardless of priority pointer.
REQ-019 SHALL, with both valid, grant the requester named by a 1-bit priority pointer.
REQ-020 SHALL set the pointer to the other requester after every grant, so sustained contention alternates 0,1,0,1...
REQ-021 SHALL leave the pointer unchanged in cycles with no grant.
REQ-022 SHALL capture the granted waddr/wdata into a one-entry stage register at the transfer edge; stage valid = 1 iff a transfer occurred at that edge.
REQ-023 SHALL drive rf_wen = stage valid AND stage waddr != 0; rf_waddr/rf_wdata = stage contents (latency: accepted at edge N, rf_wen high during cycle N..N+1, register written at edge N+1).
REQ-024 SHALL accept and silently discard requests with waddr=0 (ready asserted, rf_wen stays 0).
REQ-025 SHALL drain the stage every cycle; no backpressure from the register file; wb_en=0 does not suppress a staged write.
REQ-026 SHALL drive fwd_hitK=1 when rf_wen=1 and qaddrK == rf_waddr, else 0; fwd_dataK = rf_wdata when hit, else 0.
REQ-027 SHALL hold fwd_hitK=0 for qaddrK=0 in all cases.
REQ-028 SHALL treat both requesters targeting the same address in one cycle as two separate grants in pointer order; the later write wins in the register file.
REQ-029 SHALL contain no combinational path from rf_* outputs to reqN_ready; reqN_ready depends only on valids, wb_en and the pointer.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force stage valid=0, stage waddr/wdata=0, pointer=0 (requester 0 priority).
REQ-031 SHALL, during reset, drive req0_ready=req1_ready=0, rf_wen=0, rf_waddr=0, rf_wdata=0, fwd_hit1=fwd_hit2=0.
REQ-032 SHALL discard a staged write when reset asserts mid-operation; no write emerges after reset release.
REQ-033 SHALL resume granting on the first posedge after rst_n deasserts.

Verification
REQ-034 SHALL cover: req0 only, waddr=5, wdata=0xDEADBEEF -> req0_ready=1 same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-035 SHALL cover: both valid for 4 cycles after reset, addrs 3 and 4 -> grant order 0,1,0,1; rf_waddr sequence 3,4,3,4.
REQ-036 SHALL cover: req1 waddr=0, wdata=0x1234 -> req1_ready=1, rf_wen stays 0, fwd_hit1=0 with qaddr1=0.
REQ-037 SHALL cover: staged write addr 7 data 0xA5A5A5A5, qaddr1=7, qaddr2=8 -> fwd_hit1=1, fwd_data1=0xA5A5A5A5, fwd_hit2=0, fwd_data2=0.
REQ-038 SHALL cover: wb_en=0 with both valid -> both ready=0, pointer unchanged; already-staged write still produces rf_wen=1 once.
REQ-039 SHALL cover: rst_n pulsed low mid-cycle with stage valid -> rf_wen=0 immediately; after release, both valid -> requester 0 granted first.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of write-back requests, register-file write port and bypass lookups
// shared between the arbiter and whatever drives it.
interface rf_wb_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  wb_en;
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_waddr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_waddr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  req1_ready;
    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic [ADDR_WIDTH-1:0] qaddr1;
    logic [ADDR_WIDTH-1:0] qaddr2;
    logic                  fwd_hit1;
    logic                  fwd_hit2;
    logic [DATA_WIDTH-1:0] fwd_data1;
    logic [DATA_WIDTH-1:0] fwd_data2;

    modport slave (
        input  wb_en,
        input  req0_valid, req0_waddr, req0_wdata,
        output req0_ready,
        input  req1_valid, req1_waddr, req1_wdata,
        output req1_ready,
        output rf_wen, rf_waddr, rf_wdata,
        input  qaddr1, qaddr2,
        output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
    );

    modport master (
        output wb_en,
        output req0_valid, req0_waddr, req0_wdata,
        input  req0_ready,
        output req1_valid, req1_waddr, req1_wdata,
        input  req1_ready,
        input  rf_wen, rf_waddr, rf_wdata,
        output qaddr1, qaddr2,
        input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Two-requester round-robin write-back arbiter feeding a single register-file
// write port through a one-entry stage, with bypass of the staged write.
module rf_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic            clk,
    input logic            rst_n,
    rf_wb_arbiter_if.slave bus
);

    logic                  prio_ptr;
    logic                  gnt0_p0;
    logic                  gnt1_p0;
    logic                  vld_p1;
    logic [ADDR_WIDTH-1:0] waddr_p1;
    logic [DATA_WIDTH-1:0] wdata_p1;
    logic                  wen_p1;

    // Stage p0: grant decision from valids, wb_en and pointer only.
    always_comb begin
        gnt0_p0 = 1'b0;
        gnt1_p0 = 1'b0;
        if (rst_n && bus.wb_en) begin
            if (bus.req0_valid && (!bus.req1_valid || !prio_ptr))
                gnt0_p0 = 1'b1;
            else if (bus.req1_valid)
                gnt1_p0 = 1'b1;
        end
    end

    assign bus.req0_ready = gnt0_p0;
    assign bus.req1_ready = gnt1_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_ptr <= 1'b0;
        end else if (gnt0_p0) begin
            prio_ptr <= 1'b1;
        end else if (gnt1_p0) begin
            prio_ptr <= 1'b0;
        end
    end

    // Stage p1: accepted write, drained unconditionally on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
        end else begin
            vld_p1 <= gnt0_p0 | gnt1_p0;
            if (gnt0_p0) begin
                waddr_p1 <= bus.req0_waddr;
                wdata_p1 <= bus.req0_wdata;
            end else if (gnt1_p0) begin
                waddr_p1 <= bus.req1_waddr;
                wdata_p1 <= bus.req1_wdata;
            end
        end
    end

    // Writes to register 0 are accepted but never reach the register file.
    assign wen_p1       = vld_p1 && (waddr_p1 != '0);
    assign bus.rf_wen   = wen_p1;
    assign bus.rf_waddr = waddr_p1;
    assign bus.rf_wdata = wdata_p1;

    assign bus.fwd_hit1  = wen_p1 && (bus.qaddr1 != '0) && (bus.qaddr1 == waddr_p1);
    assign bus.fwd_hit2  = wen_p1 && (bus.qaddr2 != '0) && (bus.qaddr2 == waddr_p1);
    assign bus.fwd_data1 = bus.fwd_hit1 ? wdata_p1 : '0;
    assign bus.fwd_data2 = bus.fwd_hit2 ? wdata_p1 : '0;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: arbitration order, staging latency,
// register-0 discard, bypass, wb_en gating and mid-operation reset.
module tb_rf_wb_arbiter;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    rf_wb_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    rf_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.wb_en      = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req0_waddr = '0;
        bus.req0_wdata = '0;
        bus.req1_valid = 1'b0;
        bus.req1_waddr = '0;
        bus.req1_wdata = '0;
        bus.qaddr1     = '0;
        bus.qaddr2     = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_waddr = 5'd3;
        bus.qaddr1     = 5'd3;
        next_cycle();
        total++; if (bus.req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0 got=%b exp=0", bus.req0_ready); end
        total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready1 got=%b exp=0", bus.req1_ready); end
        total++; if (bus.rf_wen !== 1'b0) begin bad++; $display("FAIL reset_rf_wen got=%b exp=0", bus.rf_wen); end
        total++; if (bus.rf_waddr !== 5'd0) begin bad++; $display("FAIL reset_rf_waddr got=%0d exp=0", bus.rf_waddr); end
        total++; if (bus.rf_wdata !== 32'd0) begin bad++; $display("FAIL reset_rf_wdata got=%h exp=0", bus.rf_wdata); end
        total++; if (bus.fwd_hit1 !== 1'b0 || bus.fwd_hit2 !== 1'b0) begin bad++; $display("FAIL reset_fwd_hit got=%b%b exp=00", bus.fwd_hit1, bus.fwd_hit2); end
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_waddr = 5'd5;
        bus.req0_wdata = 32'hDEADBEEF;
        #1;
        total++; if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL single_ready0 got=%b exp=1", bus.req0_ready); end
        total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL single_ready1 got=%b exp=0", bus.req1_ready); end
        total++; if (bus.rf_wen !== 1'b0) begin bad++; $display("FAIL single_wen_early got=%b exp=0", bus.rf_wen); end
        next_cycle();
        bus.req0_valid = 1'b0;
        total++; if (bus.rf_wen !== 1'b1) begin bad++; $display("FAIL single_wen got=%b exp=1", bus.rf_wen); end
        total++; if (bus.rf_waddr !== 5'd5) begin bad++; $display("FAIL single_waddr got=%0d exp=5", bus.rf_waddr); end
        total++; if (bus.rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wdata got=%h exp=deadbeef", bus.rf_wdata); end
        next_cycle();
        total++; if (bus.rf_wen !== 1'b0) begin bad++; $display("FAIL single_wen_drain got=%b exp=0", bus.rf_wen); end
    endtask

    task automatic test_alternate();
        logic [4:0] exp_addr;
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_waddr = 5'd3;
        bus.req0_wdata = 32'h0000_0333;
        bus.req1_valid = 1'b1;
        bus.req1_waddr = 5'd4;
        bus.req1_wdata = 32'h0000_0444;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_addr = (i % 2 == 0) ? 5'd3 : 5'd4;
            total++; if (bus.req0_ready !== (i % 2 == 0)) begin bad++; $display("FAIL alt_ready0[%0d] got=%b exp=%b", i, bus.req0_ready, (i % 2 == 0)); end
            total++; if (bus.req1_ready !== (i % 2 == 1)) begin bad++; $display("FAIL alt_ready1[%0d] got=%b exp=%b", i, bus.req1_ready, (i % 2 == 1)); end
            next_cycle();
            total++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== exp_addr) begin bad++; $display("FAIL alt_rf[%0d] got wen=%b addr=%0d exp wen=1 addr=%0d", i, bus.rf_wen, bus.rf_waddr, exp_addr); end
        end
        idle_inputs();
    endtask

    task automatic test_discard();
        do_reset();
        bus.req1_valid = 1'b1;
        bus.req1_waddr = 5'd0;
        bus.req1_wdata = 32'h0000_1234;
        bus.qaddr1     = 5'd0;
        #1;
        total++; if (bus.req1_ready !== 1'b1) begin bad++; $display("FAIL discard_ready1 got=%b exp=1", bus.req1_ready); end
        next_cycle();
        bus.req1_valid = 1'b0;
        total++; if (bus.rf_wen !== 1'b0) begin bad++; $display("FAIL discard_wen got=%b exp=0", bus.rf_wen); end
        total++; if (bus.fwd_hit1 !== 1'b0) begin bad++; $display("FAIL discard_fwd_hit1 got=%b exp=0", bus.fwd_hit1); end
        next_cycle();
        total++; if (bus.rf_wen !== 1'b0) begin bad++; $display("FAIL discard_wen_later got=%b exp=0", bus.rf_wen); end
    endtask

    task automatic test_forward();
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_waddr = 5'd7;
        bus.req0_wdata = 32'hA5A5A5A5;
        bus.qaddr1     = 5'd7;
        bus.qaddr2     = 5'd8;
        #1;
        total++; if (bus.fwd_hit1 !== 1'b0) begin bad++; $display("FAIL fwd_hit1_early got=%b exp=0", bus.fwd_hit1); end
        next_cycle();
        bus.req0_valid = 1'b0;
        total++; if (bus.fwd_hit1 !== 1'b1) begin bad++; $display("FAIL fwd_hit1 got=%b exp=1", bus.fwd_hit1); end
        total++; if (bus.fwd_data1 !== 32'hA5A5A5A5) begin bad++; $display("FAIL fwd_data1 got=%h exp=a5a5a5a5", bus.fwd_data1); end
        total++; if (bus.fwd_hit2 !== 1'b0) begin bad++; $display("FAIL fwd_hit2 got=%b exp=0", bus.fwd_hit2); end
        total++; if (bus.fwd_data2 !== 32'd0) begin bad++; $display("FAIL fwd_data2 got=%h exp=0", bus.fwd_data2); end
        bus.qaddr2 = 5'd7;
        #1;
        total++; if (bus.fwd_hit2 !== 1'b1 || bus.fwd_data2 !== 32'hA5A5A5A5) begin bad++; $display("FAIL fwd_port2 got hit=%b data=%h exp hit=1 data=a5a5a5a5", bus.fwd_hit2, bus.fwd_data2); end
        idle_inputs();
    endtask

    task automatic test_wb_en();
        do_reset();
        // grant to requester 0 moves the pointer to requester 1
        bus.req0_valid = 1'b1;
        bus.req0_waddr = 5'd9;
        bus.req0_wdata = 32'h0000_0999;
        next_cycle();
        bus.wb_en      = 1'b0;
        bus.req0_waddr = 5'd3;
        bus.req1_valid = 1'b1;
        bus.req1_waddr = 5'd4;
        #1;
        total++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin bad++; $display("FAIL wben_ready got=%b%b exp=00", bus.req0_ready, bus.req1_ready); end
        total++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd9) begin bad++; $display("FAIL wben_staged got wen=%b addr=%0d exp wen=1 addr=9", bus.rf_wen, bus.rf_waddr); end
        next_cycle();
        total++; if (bus.rf_wen !== 1'b0) begin bad++; $display("FAIL wben_once got=%b exp=0", bus.rf_wen); end
        total++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin bad++; $display("FAIL wben_ready2 got=%b%b exp=00", bus.req0_ready, bus.req1_ready); end
        bus.wb_en = 1'b1;
        #1;
        total++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1) begin bad++; $display("FAIL wben_ptr_held got=%b%b exp=01", bus.req0_ready, bus.req1_ready); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_waddr = 5'd10;
        bus.req0_wdata = 32'h0000_1010;
        next_cycle();
        total++; if (bus.rf_wen !== 1'b1) begin bad++; $display("FAIL rmid_staged got=%b exp=1", bus.rf_wen); end
        bus.req1_valid = 1'b1;
        bus.req0_waddr = 5'd3;
        bus.req1_waddr = 5'd4;
        rst_n = 1'b0;
        #1;
        total++; if (bus.rf_wen !== 1'b0 || bus.rf_waddr !== 5'd0) begin bad++; $display("FAIL rmid_wen_now got wen=%b addr=%0d exp wen=0 addr=0", bus.rf_wen, bus.rf_waddr); end
        total++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready got=%b%b exp=00", bus.req0_ready, bus.req1_ready); end
        next_cycle();
        rst_n = 1'b1;
        #1;
        total++; if (bus.rf_wen !== 1'b0) begin bad++; $display("FAIL rmid_no_stale got=%b exp=0", bus.rf_wen); end
        total++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin bad++; $display("FAIL rmid_first_grant got=%b%b exp=10", bus.req0_ready, bus.req1_ready); end
        next_cycle();
        total++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd3) begin bad++; $display("FAIL rmid_resume got wen=%b addr=%0d exp wen=1 addr=3", bus.rf_wen, bus.rf_waddr); end
        idle_inputs();
    endtask

    task automatic test_same_addr();
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_waddr = 5'd12;
        bus.req0_wdata = 32'h0000_0111;
        bus.req1_valid = 1'b1;
        bus.req1_waddr = 5'd12;
        bus.req1_wdata = 32'h0000_0222;
        bus.qaddr1     = 5'd12;
        next_cycle();
        bus.req0_valid = 1'b0;
        total++; if (bus.rf_wdata !== 32'h0000_0111 || bus.fwd_data1 !== 32'h0000_0111) begin bad++; $display("FAIL same_first got rf=%h fwd=%h exp=111", bus.rf_wdata, bus.fwd_data1); end
        #1;
        total++; if (bus.req1_ready !== 1'b1) begin bad++; $display("FAIL same_ready1 got=%b exp=1", bus.req1_ready); end
        next_cycle();
        bus.req1_valid = 1'b0;
        total++; if (bus.rf_wen !== 1'b1 || bus.rf_wdata !== 32'h0000_0222 || bus.fwd_data1 !== 32'h0000_0222) begin bad++; $display("FAIL same_second got wen=%b rf=%h fwd=%h exp wen=1 data=222", bus.rf_wen, bus.rf_wdata, bus.fwd_data1); end
        next_cycle();
        total++; if (bus.rf_wen !== 1'b0) begin bad++; $display("FAIL same_drain got=%b exp=0", bus.rf_wen); end
        idle_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_alternate();
        test_discard();
        test_forward();
        test_wb_en();
        test_reset_mid();
        test_same_addr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
